// File: rtl/ts_null_packet_inserter_if.sv
// -----------------------------------------------------------------------------
// ts_null_packet_inserter_if
// Byte-stream bundle between the TS capture path / modulator and the
// null packet inserter.
//   in_valid    : input byte strobe
//   in_data     : input byte
//   in_sync     : first byte of an input packet (qualified by in_valid)
//   out_req     : one-cycle byte request from the modulator TS clock
//   out_valid   : output byte strobe (registered, cycle after out_req)
//   out_data    : output byte
//   out_sync    : high with byte 0 of every output packet
//   out_is_null : high for every byte of an inserted null packet
// Modports: slave = the inserter, master = the surrounding logic / bench.
// -----------------------------------------------------------------------------
interface ts_null_packet_inserter_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_sync;
   logic       out_req;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sync;
   logic       out_is_null;

   modport slave (
      input  in_valid, in_data, in_sync, out_req,
      output out_valid, out_data, out_sync, out_is_null
   );

   modport master (
      output in_valid, in_data, in_sync, out_req,
      input  out_valid, out_data, out_sync, out_is_null
   );
endinterface

// File: rtl/ts_null_packet_inserter.sv
// -----------------------------------------------------------------------------
// ts_null_packet_inserter
// Transport-stream rate adapter. Whole 188-byte packets are buffered in a
// packet-slot FIFO; bytes are served one per out_req. When no complete packet
// is available at a packet boundary a DVB null packet (PID 0x1FFF) is emitted
// instead, so the downstream modulator sees a constant-rate aligned stream.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : byte in/out bundle (slave side)
//   null_en     : 1 = insert null packets when starved
//   pkt_count   : input packets committed
//   null_count  : null packets started
//   drop_count  : input packets discarded
//   sync_err    : one-cycle pulse on a malformed or truncated input packet
// -----------------------------------------------------------------------------
module ts_null_packet_inserter #(
   parameter int SLOTS     = 4,
   parameter int SLOT_BITS = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   ts_null_packet_inserter_if.slave       bus,
   input  logic                           null_en,
   output logic [31:0]                    pkt_count,
   output logic [31:0]                    null_count,
   output logic [31:0]                    drop_count,
   output logic                           sync_err
);

   localparam int                 PKT_LEN   = 188;
   localparam int                 DEPTH     = SLOTS * PKT_LEN;
   localparam int                 ADDR_W    = $clog2(DEPTH);
   localparam logic [7:0]         SYNC_BYTE = 8'h47;
   localparam logic [7:0]         LAST_IDX  = 8'd187;
   localparam logic [SLOT_BITS:0] SLOTS_CNT = (SLOT_BITS + 1)'(SLOTS);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP}  wr_state_t;
   typedef enum logic [1:0] {R_BOUND, R_FIFO, R_NULL} rd_state_t;

   // Linear byte address of (slot, index) in the packet RAM.
   function automatic logic [ADDR_W-1:0] byte_addr(input logic [SLOT_BITS-1:0] slot,
                                                   input logic [7:0]           idx);
      return ADDR_W'(slot) * ADDR_W'(PKT_LEN) + ADDR_W'(idx);
   endfunction

   // Null packet: sync, PID 0x1FFF, payload-only/CC 0, then 0xFF stuffing.
   function automatic logic [7:0] null_byte(input logic [7:0] idx);
      logic [7:0] b;
      case (idx)
         8'd0:    b = 8'h47;
         8'd1:    b = 8'h1F;
         8'd2:    b = 8'hFF;
         8'd3:    b = 8'h10;
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

   logic [7:0] mem [0:DEPTH-1];

   wr_state_t            wr_state_q;
   logic [SLOT_BITS-1:0] wr_slot_q;
   logic [7:0]           wr_idx_q;
   logic [SLOT_BITS:0]   committed_q;
   logic                 sync_err_q;
   logic [31:0]          pkt_count_q;
   logic [31:0]          drop_count_q;

   rd_state_t            rd_state_q;
   logic [SLOT_BITS-1:0] rd_slot_q;
   logic [7:0]           rd_idx_q;
   logic                 out_valid_q;
   logic [7:0]           out_data_q;
   logic                 out_sync_q;
   logic                 out_is_null_q;
   logic [31:0]          null_count_q;

   // ---------------------------------------------------------------------------
   // Writer decisions
   // ---------------------------------------------------------------------------
   logic        slot_free;
   logic        w_start;   // good sync byte with a free slot
   logic        w_bad;     // sync byte with wrong value
   logic        w_full;    // good sync byte but every slot committed
   logic        w_abort;   // sync seen while a packet was still filling
   logic        w_commit;  // last byte of a packet written
   logic        wr_we;
   logic [7:0]  wr_idx_sel;

   assign slot_free = (committed_q < SLOTS_CNT);

   always_comb begin
      w_start    = 1'b0;
      w_bad      = 1'b0;
      w_full     = 1'b0;
      w_abort    = 1'b0;
      w_commit   = 1'b0;
      wr_we      = 1'b0;
      wr_idx_sel = wr_idx_q;
      if (bus.in_valid) begin
         if (bus.in_sync) begin
            // A sync byte always restarts evaluation, whatever the state.
            w_abort = (wr_state_q == W_FILL);
            if (bus.in_data != SYNC_BYTE) begin
               w_bad = 1'b1;
            end else if (!slot_free) begin
               w_full = 1'b1;
            end else begin
               w_start    = 1'b1;
               wr_we      = 1'b1;
               wr_idx_sel = 8'd0;
            end
         end else if (wr_state_q == W_FILL) begin
            wr_we    = 1'b1;
            w_commit = (wr_idx_q == LAST_IDX);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_we) begin
         mem[byte_addr(wr_slot_q, wr_idx_sel)] <= bus.in_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Writer FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_q   <= W_IDLE;
         wr_slot_q    <= '0;
         wr_idx_q     <= 8'd0;
         sync_err_q   <= 1'b0;
         pkt_count_q  <= 32'd0;
         drop_count_q <= 32'd0;
      end else begin
         sync_err_q   <= w_abort | w_bad;
         // An abort followed by a rejected sync byte drops two packets.
         drop_count_q <= drop_count_q + 32'(w_abort) + 32'(w_bad | w_full);
         if (w_start) begin
            wr_state_q <= W_FILL;
            wr_idx_q   <= 8'd1;
         end else if (w_bad || w_full) begin
            wr_state_q <= W_SKIP;
            wr_idx_q   <= 8'd0;
         end else if (w_commit) begin
            wr_state_q  <= W_IDLE;
            wr_idx_q    <= 8'd0;
            wr_slot_q   <= wr_slot_q + 1'b1;
            pkt_count_q <= pkt_count_q + 32'd1;
         end else if (wr_we) begin
            wr_idx_q <= wr_idx_q + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Reader decisions
   // ---------------------------------------------------------------------------
   logic        r_fifo;   // this request is served from the FIFO
   logic        r_null;   // this request is served from the null generator
   logic        r_last;
   logic        r_free;
   logic [7:0]  r_idx;

   assign r_idx = (rd_state_q == R_BOUND) ? 8'd0 : rd_idx_q;

   always_comb begin
      r_fifo = 1'b0;
      r_null = 1'b0;
      if (bus.out_req) begin
         case (rd_state_q)
            R_BOUND: begin
               // committed_q already reflects a commit from the previous cycle.
               if (committed_q != '0) begin
                  r_fifo = 1'b1;
               end else if (null_en) begin
                  r_null = 1'b1;
               end
            end
            R_FIFO:  r_fifo = 1'b1;
            R_NULL:  r_null = 1'b1;
            default: begin
               r_fifo = 1'b0;
               r_null = 1'b0;
            end
         endcase
      end
      r_last = (r_fifo | r_null) & (r_idx == LAST_IDX);
      r_free = r_last & r_fifo;
   end

   // ---------------------------------------------------------------------------
   // Reader FSM and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_state_q    <= R_BOUND;
         rd_slot_q     <= '0;
         rd_idx_q      <= 8'd0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 8'd0;
         out_sync_q    <= 1'b0;
         out_is_null_q <= 1'b0;
         null_count_q  <= 32'd0;
      end else begin
         out_valid_q   <= r_fifo | r_null;
         out_sync_q    <= (r_fifo | r_null) & (r_idx == 8'd0);
         out_is_null_q <= r_null;
         if (r_fifo) begin
            out_data_q <= mem[byte_addr(rd_slot_q, r_idx)];
         end else if (r_null) begin
            out_data_q <= null_byte(r_idx);
         end
         if (r_null && rd_state_q == R_BOUND) begin
            null_count_q <= null_count_q + 32'd1;
         end
         if (r_last) begin
            rd_state_q <= R_BOUND;
            rd_idx_q   <= 8'd0;
            if (r_free) begin
               rd_slot_q <= rd_slot_q + 1'b1;
            end
         end else if (r_fifo) begin
            rd_state_q <= R_FIFO;
            rd_idx_q   <= r_idx + 8'd1;
         end else if (r_null) begin
            rd_state_q <= R_NULL;
            rd_idx_q   <= r_idx + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Committed-slot count shared by both sides
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         committed_q <= '0;
      end else begin
         case ({w_commit, r_free})
            2'b10:   committed_q <= committed_q + 1'b1;
            2'b01:   committed_q <= committed_q - 1'b1;
            default: committed_q <= committed_q;
         endcase
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_sync    = out_sync_q;
   assign bus.out_is_null = out_is_null_q;
   assign pkt_count       = pkt_count_q;
   assign null_count      = null_count_q;
   assign drop_count      = drop_count_q;
   assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_ts_null_packet_inserter.sv
// -----------------------------------------------------------------------------
// tb_ts_null_packet_inserter
// Directed bench for ts_null_packet_inserter (SLOTS = 4). Input packet k has
// byte 0 = 0x47 and byte i = (37*k + i) mod 256 for i >= 1.
// -----------------------------------------------------------------------------
module tb_ts_null_packet_inserter;

   logic        clk;
   logic        rst_n;
   logic        null_en;
   logic [31:0] pkt_count;
   logic [31:0] null_count;
   logic [31:0] drop_count;
   logic        sync_err;

   int n_checks;
   int n_fail;
   int se_cycles;
   logic [7:0] cap [0:187];

   ts_null_packet_inserter_if ifc ();

   ts_null_packet_inserter #(
      .SLOTS     (4),
      .SLOT_BITS (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (ifc),
      .null_en    (null_en),
      .pkt_count  (pkt_count),
      .null_count (null_count),
      .drop_count (drop_count),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sync_err === 1'b1) se_cycles++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pat(input int k, input int i);
      return (i == 0) ? 8'h47 : 8'((37 * k + i) % 256);
   endfunction

   function automatic logic [7:0] nullb(input int i);
      if (i == 0) return 8'h47;
      if (i == 1) return 8'h1F;
      if (i == 3) return 8'h10;
      return 8'hFF;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic s);
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_sync  = s;
      tick();
      ifc.in_valid = 1'b0;
      ifc.in_sync  = 1'b0;
   endtask

   // Send bytes [start, start+n) of packet k; byte 0 uses sync0 as its value.
   task automatic send_range(input int k, input int start, input int n, input logic [7:0] sync0);
      for (int i = start; i < start + n; i++) begin
         send_byte((i == 0) ? sync0 : pat(k, i), i == 0);
      end
   endtask

   // Request bytes [start, start+n) back-to-back and compare every output.
   task automatic read_bytes(input bit isnull, input int k, input int start, input int n,
                             input string tag);
      int ev = 0;
      int ed = 0;
      int es = 0;
      int en = 0;
      logic [7:0] e;
      for (int i = start; i < start + n; i++) begin
         ifc.out_req = 1'b1;
         tick();
         e = isnull ? nullb(i) : pat(k, i);
         if (ifc.out_valid !== 1'b1) ev++;
         if (ifc.out_data !== e) ed++;
         if (ifc.out_sync !== (i == 0)) es++;
         if (ifc.out_is_null !== isnull) en++;
         cap[i] = ifc.out_data;
      end
      ifc.out_req = 1'b0;
      chk({tag, "_valid_errs"}, ev, 0);
      chk({tag, "_data_errs"}, ed, 0);
      chk({tag, "_sync_errs"}, es, 0);
      chk({tag, "_isnull_errs"}, en, 0);
   endtask

   initial begin
      int se0;
      n_checks     = 0;
      n_fail       = 0;
      se_cycles    = 0;
      rst_n        = 1'b0;
      null_en      = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'h00;
      ifc.in_sync  = 1'b0;
      ifc.out_req  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_out_data", ifc.out_data, 0);
      chk("rst_out_sync", ifc.out_sync, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_null_count", null_count, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_sync_err", sync_err, 0);

      // FIFO path: packet 0 = 0x47,1..187; read starts the cycle after commit
      send_range(0, 0, 188, 8'h47);
      chk("fifo_pkt_count", pkt_count, 1);
      read_bytes(1'b0, 0, 0, 188, "fifo");
      tick();
      chk("fifo_idle_valid", ifc.out_valid, 0);

      // Starvation: two null packets
      null_en = 1'b1;
      read_bytes(1'b1, 0, 0, 188, "null1");
      chk("null_b1", cap[1], 8'h1F);
      chk("null_b3", cap[3], 8'h10);
      read_bytes(1'b1, 0, 0, 188, "null2");
      chk("null_count_2", null_count, 2);

      // Packet commits while a null packet sits at byte 50
      read_bytes(1'b1, 0, 0, 50, "mid_null_a");
      send_range(1, 0, 188, 8'h47);
      chk("mid_pkt_count", pkt_count, 2);
      read_bytes(1'b1, 0, 50, 138, "mid_null_b");
      read_bytes(1'b0, 1, 0, 188, "mid_fifo");
      chk("mid_null_count", null_count, 3);

      // Truncation at byte 100, new packet stored intact
      null_en = 1'b0;
      se0 = se_cycles;
      send_range(2, 0, 100, 8'h47);
      send_byte(8'h47, 1'b1);
      chk("trunc_sync_err_hi", sync_err, 1);
      chk("trunc_drop", drop_count, 1);
      send_range(3, 1, 1, 8'h47);
      chk("trunc_sync_err_lo", sync_err, 0);
      send_range(3, 2, 186, 8'h47);
      chk("trunc_pulse_cycles", se_cycles - se0, 1);
      chk("trunc_pkt_count", pkt_count, 3);
      read_bytes(1'b0, 3, 0, 188, "trunc_fifo");

      // Overflow: five packets into four slots, no reads
      se0 = se_cycles;
      for (int k = 4; k < 9; k++) send_range(k, 0, 188, 8'h47);
      chk("ovf_drop", drop_count, 2);
      chk("ovf_pkt_count", pkt_count, 7);
      chk("ovf_no_sync_err", se_cycles - se0, 0);
      for (int k = 4; k < 8; k++) read_bytes(1'b0, k, 0, 188, $sformatf("ovf_rd%0d", k));

      // Bad sync byte 0x48
      se0 = se_cycles;
      send_range(9, 0, 188, 8'h48);
      chk("bad_drop", drop_count, 3);
      chk("bad_pkt_count", pkt_count, 7);
      chk("bad_pulse_cycles", se_cycles - se0, 1);
      for (int i = 0; i < 3; i++) begin
         ifc.out_req = 1'b1;
         tick();
         chk($sformatf("starve_noen_valid%0d", i), ifc.out_valid, 0);
      end
      ifc.out_req = 1'b0;
      null_en = 1'b1;
      read_bytes(1'b1, 0, 0, 188, "bad_then_null");
      chk("bad_null_count", null_count, 4);

      // Reset mid-packet discards buffered data; request at reset release ignored
      null_en = 1'b0;
      send_range(10, 0, 188, 8'h47);
      send_range(11, 0, 50, 8'h47);
      rst_n = 1'b0;
      ifc.out_req = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst2_req_valid", ifc.out_valid, 0);
      ifc.out_req = 1'b0;
      chk("rst2_pkt_count", pkt_count, 0);
      chk("rst2_null_count", null_count, 0);
      chk("rst2_drop_count", drop_count, 0);
      send_range(12, 1, 40, 8'h47);
      send_range(12, 0, 188, 8'h47);
      chk("rst2_pkt_count_1", pkt_count, 1);
      read_bytes(1'b0, 12, 0, 188, "rst2_fifo");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
